seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 215 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Ops 0-9 and 14-15 produce a result one cycle after accept. MUL/MULHU use a
// one-bit-per-cycle shift-add multiplier, and DIVU/REMU use a restoring divider.
// Both iterative paths present the result WIDTH+1 cycles after the accept cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous abort of any in-flight op and pending result
//   in_valid/in_ready request handshake carrying A, B, op
//   A, B              operands (WIDTH bits)
//   op                opcode, all 16 codes defined
//   out_valid/out_ready result handshake carrying C, f
//   C                 result (WIDTH bits)
//   f                 compare flag (SLT, SLTU, EQ, NE); 0 for other ops
//   busy              high while an iterative op is in progress
module seq_alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             f,
   output logic             busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_IT = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_MULHU = 4'd11;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_REMU  = 4'd13;
   localparam logic [3:0] OP_EQ    = 4'd14;
   localparam logic [3:0] OP_NE    = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               accept_c;
   logic               is_mul_c;
   logic               is_div_c;
   logic               last_c;
   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   acc;     // product high half / partial remainder
   logic [WIDTH-1:0]   qr;      // multiplier bits / dividend-then-quotient bits
   logic [WIDTH-1:0]   opnd;    // captured multiplicand / divisor
   logic               sel_hi;  // MULHU or REMU: return acc instead of qr
   logic [WIDTH-1:0]   alu_r_c;
   logic               alu_f_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH:0]     div_sh_c;
   logic [WIDTH:0]     div_diff_c;
   logic [WIDTH-1:0]   acc_n_c;
   logic [WIDTH-1:0]   qr_n_c;
   logic [WIDTH-1:0]   iter_res_c;
   logic [SHW-1:0]     sh_c;

   assign accept_c = in_valid && in_ready;
   assign is_mul_c = (op == OP_MUL) || (op == OP_MULHU);
   assign is_div_c = (op == OP_DIVU) || (op == OP_REMU);
   assign last_c   = (cnt == LAST_IT);
   assign sh_c     = B[SHW-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; flush wins over accept and completion
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_c && is_mul_c)      state_d = S_MUL;
               else if (accept_c && is_div_c) state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
               if (last_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      busy     = 1'b0;
      in_ready = 1'b0;
      busy     = (state_q != S_IDLE);
      in_ready = (state_q == S_IDLE) && (!out_valid || out_ready) && !flush;
   end

   // Single-cycle datapath
   always_comb begin
      alu_r_c = '0;
      alu_f_c = 1'b0;
      case (op)
         OP_ADD:  alu_r_c = A + B;
         OP_SUB:  alu_r_c = A - B;
         OP_AND:  alu_r_c = A & B;
         OP_OR:   alu_r_c = A | B;
         OP_XOR:  alu_r_c = A ^ B;
         OP_SLL:  alu_r_c = A << sh_c;
         OP_SRL:  alu_r_c = A >> sh_c;
         OP_SRA:  alu_r_c = $signed(A) >>> sh_c;
         OP_SLT:  alu_f_c = $signed(A) < $signed(B);
         OP_SLTU: alu_f_c = A < B;
         OP_EQ:   alu_f_c = A == B;
         OP_NE:   alu_f_c = A != B;
         default: alu_r_c = '0;
      endcase
      if ((op == OP_SLT) || (op == OP_SLTU) || (op == OP_EQ) || (op == OP_NE))
         alu_r_c = {{(WIDTH-1){1'b0}}, alu_f_c};
   end

   // One iteration step of the multiplier or the divider
   always_comb begin
      mul_sum_c  = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
      div_sh_c   = {acc, qr[WIDTH-1]};
      div_diff_c = div_sh_c - {1'b0, opnd};
      acc_n_c    = acc;
      qr_n_c     = qr;
      if (state_q == S_MUL) begin
         acc_n_c = mul_sum_c[WIDTH:1];
         qr_n_c  = {mul_sum_c[0], qr[WIDTH-1:1]};
      end else if (!div_diff_c[WIDTH]) begin
         // partial remainder >= divisor: keep difference, quotient bit 1.
         // A zero divisor always lands here, giving all-ones and remainder A.
         acc_n_c = div_diff_c[WIDTH-1:0];
         qr_n_c  = {qr[WIDTH-2:0], 1'b1};
      end else begin
         acc_n_c = div_sh_c[WIDTH-1:0];
         qr_n_c  = {qr[WIDTH-2:0], 1'b0};
      end
      iter_res_c = sel_hi ? acc_n_c : qr_n_c;
   end

   // Result, operand capture and iteration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         C         <= '0;
         f         <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         qr        <= '0;
         opnd      <= '0;
         sel_hi    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         C         <= '0;
         f         <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (out_valid && out_ready) out_valid <= 1'b0;
               if (accept_c) begin
                  if (is_mul_c || is_div_c) begin
                     acc    <= '0;
                     qr     <= A;
                     opnd   <= B;
                     sel_hi <= op[0];
                     cnt    <= '0;
                  end else begin
                     C         <= alu_r_c;
                     f         <= alu_f_c;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc <= acc_n_c;
               qr  <= qr_n_c;
               cnt <= cnt + SHW'(1);
               if (last_c) begin
                  C         <= iter_res_c;
                  f         <= 1'b0;
                  out_valid <= 1'b1;
                  cnt       <= '0;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;

   localparam int unsigned W = 32;

   localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
   localparam logic [3:0] XOR_ = 4'd4, SLL = 4'd5,  SRL = 4'd6,  SRA = 4'd7;
   localparam logic [3:0] SLT = 4'd8,  SLTU = 4'd9, MUL = 4'd10, MULHU = 4'd11;
   localparam logic [3:0] DIVU = 4'd12, REMU = 4'd13, EQ = 4'd14, NE = 4'd15;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [3:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  C;
   logic          f;
   logic          busy;

   int n_chk = 0;
   int n_bad = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (C),
      .f         (f),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, scramble inputs after accept, wait for the result and consume it.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output logic fo, output int lat, output int bcnt);
      check("in_ready_pre", 32'(in_ready), 32'd1);
      op = o; A = a; B = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      A = $urandom; B = $urandom; op = 4'($urandom);
      lat = 1; bcnt = 0;
      while (!out_valid && lat < 80) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
      c = C;
      fo = f;
      tick();
   endtask

   task automatic expect_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ec, input logic ef,
                            input int elat);
      logic [31:0] c;
      logic        fo;
      int          lat;
      int          bcnt;
      run_op(o, a, b, c, fo, lat, bcnt);
      check({tag, "_c"}, c, ec);
      check({tag, "_f"}, 32'(fo), 32'(ef));
      check({tag, "_lat"}, 32'(lat), 32'(elat));
   endtask

   initial begin
      logic [31:0] c;
      logic        fo;
      int          lat;
      int          bcnt;
      int          seen;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; op = '0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_c", C, 32'd0);
      check("rst_f", 32'(f), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;

      // Single-cycle ops; the first one is accepted on the first edge after reset
      expect_op("add_wrap", ADD,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 1);
      expect_op("sub",      SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
      expect_op("and",      AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
      expect_op("or",       OR_,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1);
      expect_op("xor",      XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
      expect_op("sll",      SLL,  32'd1,         32'h24,        32'h0000_0010, 1'b0, 1);
      expect_op("srl",      SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1);
      expect_op("sra",      SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1);
      expect_op("slt",      SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b1, 1);
      expect_op("sltu",     SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1);
      expect_op("eq",       EQ,   32'd5,         32'd5,         32'd1,         1'b1, 1);
      expect_op("ne",       NE,   32'd5,         32'd5,         32'd0,         1'b0, 1);

      // Iterative multiply: busy for 32 cycles, result in cycle 33
      run_op(MUL, 32'h0001_0000, 32'h0001_0000, c, fo, lat, bcnt);
      check("mul_pow_c", c, 32'd0);
      check("mul_pow_lat", 32'(lat), 32'd33);
      check("mul_pow_busy", 32'(bcnt), 32'd32);
      expect_op("mulhu_pow", MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0, 33);
      expect_op("mul_small", MUL,   32'd1234,      32'd5678,      32'h006A_E9BC, 1'b0, 33);
      expect_op("mul_max",   MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 33);
      expect_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);

      // Iterative divide, including divide by zero
      expect_op("divu",      DIVU, 32'd100,       32'd7,  32'd14,        1'b0, 33);
      expect_op("remu",      REMU, 32'd100,       32'd7,  32'd2,         1'b0, 33);
      expect_op("divu_z",    DIVU, 32'd5,         32'd0,  32'hFFFF_FFFF, 1'b0, 33);
      expect_op("remu_z",    REMU, 32'd5,         32'd0,  32'd5,         1'b0, 33);
      expect_op("divu_big",  DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, 33);

      // Backpressure: the result holds while a competing request waits
      out_ready = 1'b0;
      op = ADD; A = 32'd3; B = 32'd4; in_valid = 1'b1;
      tick();
      A = 32'd100; B = 32'd100;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_c", C, 32'd7);
         check("hold_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         A = 32'(i); B = 32'(10 * i);
         tick();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_c", C, 32'(11 * i));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drain", 32'(out_valid), 32'd0);

      // Flush at iteration 10 of DIVU, with a competing request on the flush cycle
      op = DIVU; A = 32'd100; B = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      flush = 1'b1; op = ADD; A = 32'd2; B = 32'd3; in_valid = 1'b1;
      #1;
      check("flush_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid) seen++;
      end
      check("flush_no_result", 32'(seen), 32'd0);
      expect_op("post_flush_add",  ADD,  32'd2,   32'd3, 32'd5,  1'b0, 1);
      expect_op("post_flush_divu", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);

      // Asynchronous reset at iteration 10 of MUL
      op = MUL; A = 32'd1234; B = 32'd5678; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_c", C, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid) seen++;
      end
      check("rst_no_result", 32'(seen), 32'd0);
      expect_op("post_rst_mul", MUL, 32'd1234, 32'd5678, 32'h006A_E9BC, 1'b0, 33);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
